// File: rtl/instr_pkg.sv
// Shared instruction-set definitions: op kinds, opcodes and field positions.
// Used by both the encoder/loader and the CONTROL decoder.
package instr_pkg;

  typedef enum logic [3:0] {
    K_NOP  = 4'd0,
    K_ALU  = 4'd1,
    K_LI   = 4'd2,
    K_LUI  = 4'd3,
    K_ADDI = 4'd4,
    K_ANDI = 4'd5,
    K_ORI  = 4'd6,
    K_B    = 4'd7,
    K_BEQ  = 4'd8,
    K_BNE  = 4'd9,
    K_LB   = 4'd10,
    K_LW   = 4'd11,
    K_SB   = 4'd12,
    K_SW   = 4'd13
  } op_kind_e;

  localparam logic [5:0] OPC_ALU  = 6'b100000;
  localparam logic [5:0] OPC_LI   = 6'b111000;
  localparam logic [5:0] OPC_LUI  = 6'b111001;
  localparam logic [5:0] OPC_ADDI = 6'b110000;
  localparam logic [5:0] OPC_ANDI = 6'b110010;
  localparam logic [5:0] OPC_ORI  = 6'b110011;
  localparam logic [5:0] OPC_B    = 6'b111111;
  localparam logic [5:0] OPC_BEQ  = 6'b000000;
  localparam logic [5:0] OPC_BNE  = 6'b000001;
  localparam logic [5:0] OPC_LB   = 6'b000011;
  localparam logic [5:0] OPC_LW   = 6'b001111;
  localparam logic [5:0] OPC_SB   = 6'b000111;
  localparam logic [5:0] OPC_SW   = 6'b011111;

  // Field LSB positions; R-type bits [10:4] are zero.
  localparam int OPC_LSB  = 26;
  localparam int RS_LSB   = 21;
  localparam int RD_LSB   = 16;
  localparam int RT_LSB   = 11;
  localparam int IMM_LSB  = 0;
  localparam int FUNC_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_WRITE,
    S_RELEASE
  } ld_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: op kind plus register/immediate fields to a 32-bit word.
module instr_field_pack
  import instr_pkg::*;
(
  input  logic [3:0]  op_kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rd,
  input  logic [4:0]  rt,
  input  logic [3:0]  func,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [5:0] opc;
  logic [4:0] rs_f;
  logic [4:0] rd_f;
  logic       r_type;
  logic       emit;

  always_comb begin
    opc     = '0;
    rs_f    = rs;
    rd_f    = rd;
    r_type  = 1'b0;
    emit    = 1'b1;
    illegal = 1'b0;
    word    = '0;
    case (op_kind)
      K_NOP:  emit = 1'b0;
      K_ALU:  begin opc = OPC_ALU; r_type = 1'b1; end
      K_LI:   begin opc = OPC_LI;  rs_f = '0; end
      K_LUI:  begin opc = OPC_LUI; rs_f = '0; end
      K_ADDI: opc = OPC_ADDI;
      K_ANDI: opc = OPC_ANDI;
      K_ORI:  opc = OPC_ORI;
      K_B:    begin opc = OPC_B; rs_f = '0; rd_f = '0; end
      K_BEQ:  opc = OPC_BEQ;
      K_BNE:  opc = OPC_BNE;
      K_LB:   opc = OPC_LB;
      K_LW:   opc = OPC_LW;
      K_SB:   opc = OPC_SB;
      K_SW:   opc = OPC_SW;
      default: begin emit = 1'b0; illegal = 1'b1; end
    endcase
    if (emit) begin
      word[OPC_LSB +: 6] = opc;
      word[RS_LSB  +: 5] = rs_f;
      word[RD_LSB  +: 5] = rd_f;
      if (r_type) begin
        word[RT_LSB   +: 5] = rt;
        word[FUNC_LSB +: 4] = func;
      end else begin
        word[IMM_LSB +: 16] = imm;
      end
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: clears instruction memory, writes encoded ops sequentially,
// and holds the CPU in reset until the program is loaded.
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8,
  parameter int RST_HOLD = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load_Start,
  input  logic              Load_Done,
  input  logic              Op_Valid,
  output logic              Op_Ready,
  input  logic [3:0]        Op_Kind,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Rt,
  input  logic [3:0]        Func,
  input  logic [15:0]       Imm,
  output logic              IMem_WrEn,
  output logic [ADDR_W-1:0] IMem_Addr,
  output logic [31:0]       IMem_WrData,
  output logic              Cpu_Reset,
  output logic              Busy,
  output logic              Overflow,
  output logic              Bad_Op
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  // One extra bit so "full" (== DEPTH) differs from wrap-around to 0.
  typedef logic [ADDR_W:0] addr_t;
  localparam addr_t ADDR_LAST = addr_t'(DEPTH - 1);
  localparam addr_t ADDR_FULL = addr_t'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  ld_state_e   state_q, state_d;
  addr_t       addr_q, addr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        ovf_q, ovf_d;
  logic        bad_q, bad_d;
  logic        done_q, done_d;
  logic [31:0] word_q, word_d;

  logic [31:0] pk_word;
  logic        pk_illegal;
  logic        full;

  instr_field_pack u_pack (
    .op_kind (Op_Kind),
    .rs      (Rs),
    .rd      (Rd),
    .rt      (Rt),
    .func    (Func),
    .imm     (Imm),
    .word    (pk_word),
    .illegal (pk_illegal)
  );

  assign full = (addr_q == ADDR_FULL);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    cpu_rst_d   = cpu_rst_q;
    ovf_d       = ovf_q;
    bad_d       = bad_q;
    done_d      = done_q;
    word_d      = word_q;
    Op_Ready    = 1'b0;
    IMem_WrEn   = 1'b0;
    IMem_Addr   = '0;
    IMem_WrData = '0;
    case (state_q)
      S_IDLE: begin
        if (Load_Start) begin
          state_d   = S_CLEAR;
          addr_d    = '0;
          cpu_rst_d = 1'b1;
          ovf_d     = 1'b0;
          bad_d     = 1'b0;
          done_d    = 1'b0;
        end
      end
      S_CLEAR: begin
        IMem_WrEn = 1'b1;
        IMem_Addr = addr_q[ADDR_W-1:0];
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          state_d = S_LOAD;
        end else begin
          addr_d = addr_q + addr_t'(1);
        end
      end
      S_LOAD: begin
        Op_Ready = !full;
        if (Op_Valid && full) ovf_d = 1'b1;
        if (Op_Valid && !full) begin
          if (pk_illegal) begin
            bad_d = 1'b1;
            if (Load_Done) begin
              state_d = S_RELEASE;
              hold_d  = '0;
            end
          end else begin
            // Done arriving with an op is remembered until the op is written.
            word_d  = pk_word;
            done_d  = Load_Done;
            state_d = S_WRITE;
          end
        end else if (Load_Done) begin
          state_d = S_RELEASE;
          hold_d  = '0;
        end
      end
      S_WRITE: begin
        IMem_WrEn   = 1'b1;
        IMem_Addr   = addr_q[ADDR_W-1:0];
        IMem_WrData = word_q;
        addr_d      = addr_q + addr_t'(1);
        if (done_q) begin
          done_d  = 1'b0;
          hold_d  = '0;
          state_d = S_RELEASE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RELEASE: begin
        if (hold_q == HOLD_LAST) begin
          cpu_rst_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      hold_q    <= '0;
      cpu_rst_q <= 1'b1;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hold_q    <= hold_d;
      cpu_rst_q <= cpu_rst_d;
      ovf_q     <= ovf_d;
      bad_q     <= bad_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge Clk) begin
    word_q <= word_d;
  end

  assign Cpu_Reset = cpu_rst_q;
  assign Busy      = (state_q != S_IDLE);
  assign Overflow  = ovf_q;
  assign Bad_Op    = bad_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a DEPTH=256 instance and a DEPTH=4 instance.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ls, ld, ov;
  logic        ls_s, ld_s, ov_s;
  logic [3:0]  kind, func;
  logic [4:0]  rs, rd, rt;
  logic [15:0] imm;

  logic        rdy, we, cpu, busy, ovf, bad;
  logic [7:0]  addr;
  logic [31:0] wd;
  logic        rdy_s, we_s, cpu_s, busy_s, ovf_s, bad_s;
  logic [1:0]  addr_s;
  logic [31:0] wd_s;

  int vectors = 0;
  int miscompares = 0;

  instr_encoder_loader #(.DEPTH(256), .ADDR_W(8), .RST_HOLD(4)) dut (
    .Clk(clk), .Reset(rst), .Load_Start(ls), .Load_Done(ld), .Op_Valid(ov),
    .Op_Ready(rdy), .Op_Kind(kind), .Rs(rs), .Rd(rd), .Rt(rt), .Func(func),
    .Imm(imm), .IMem_WrEn(we), .IMem_Addr(addr), .IMem_WrData(wd),
    .Cpu_Reset(cpu), .Busy(busy), .Overflow(ovf), .Bad_Op(bad)
  );

  instr_encoder_loader #(.DEPTH(4), .ADDR_W(2), .RST_HOLD(4)) dut_s (
    .Clk(clk), .Reset(rst), .Load_Start(ls_s), .Load_Done(ld_s), .Op_Valid(ov_s),
    .Op_Ready(rdy_s), .Op_Kind(kind), .Rs(rs), .Rd(rd), .Rt(rt), .Func(func),
    .Imm(imm), .IMem_WrEn(we_s), .IMem_Addr(addr_s), .IMem_WrData(wd_s),
    .Cpu_Reset(cpu_s), .Busy(busy_s), .Overflow(ovf_s), .Bad_Op(bad_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] k, input logic [4:0] s, input logic [4:0] d,
                            input logic [4:0] t, input logic [3:0] f, input logic [15:0] i);
    kind = k; rs = s; rd = d; rt = t; func = f; imm = i;
  endtask

  // Offer one op to the large instance for one cycle; returns in WRITE (or LOAD if illegal).
  task automatic send(input logic [3:0] k, input logic [4:0] s, input logic [4:0] d,
                      input logic [4:0] t, input logic [3:0] f, input logic [15:0] i,
                      input logic done);
    set_fields(k, s, d, t, f, i);
    ov = 1'b1; ld = done;
    step();
    ov = 1'b0; ld = 1'b0;
  endtask

  task automatic send_s(input logic [3:0] k, input logic [4:0] s, input logic [4:0] d,
                        input logic [4:0] t, input logic [3:0] f, input logic [15:0] i);
    set_fields(k, s, d, t, f, i);
    ov_s = 1'b1;
    step();
    ov_s = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    vectors++; if (cpu !== 1'b1) begin miscompares++; $display("FAIL reset_cpu got %b want 1", cpu); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", we); end
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy got %b want 0", rdy); end
    vectors++; if ({ovf, bad} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b want 00", {ovf, bad}); end
    vectors++; if ({addr, wd} !== 40'h0) begin miscompares++; $display("FAIL reset_bus got %h want 0", {addr, wd}); end
    vectors++; if ({cpu_s, busy_s} !== 2'b10) begin miscompares++; $display("FAIL reset_small got %b want 10", {cpu_s, busy_s}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_clear();
    ls = 1'b1;
    step();
    ls = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL clear_busy got %b want 1", busy); end
    for (int i = 0; i < 256; i++) begin
      vectors++;
      if ({we, addr, wd, cpu} !== {1'b1, 8'(i), 32'h0, 1'b1}) begin
        miscompares++;
        $display("FAIL clear_word%0d got we=%b a=%h d=%h cpu=%b want we=1 a=%h d=0 cpu=1", i, we, addr, wd, cpu, 8'(i));
      end
      step();
    end
    vectors++; if ({rdy, we} !== 2'b10) begin miscompares++; $display("FAIL clear_to_load got rdy,we=%b want 10", {rdy, we}); end
  endtask

  task automatic test_alu_addi();
    send(4'd1, 5'd1, 5'd2, 5'd3, 4'd4, 16'h0, 1'b0);
    vectors++; if ({we, addr, wd, rdy} !== {1'b1, 8'd0, 32'h8022_1804, 1'b0}) begin
      miscompares++; $display("FAIL alu got we=%b a=%h d=%h rdy=%b want 1 00 80221804 0", we, addr, wd, rdy); end
    step();
    vectors++; if ({rdy, we} !== 2'b10) begin miscompares++; $display("FAIL alu_back got rdy,we=%b want 10", {rdy, we}); end
    send(4'd4, 5'd1, 5'd2, 5'd0, 4'd0, 16'hFFFF, 1'b0);
    vectors++; if ({we, addr, wd} !== {1'b1, 8'd1, 32'hC022_FFFF}) begin
      miscompares++; $display("FAIL addi got we=%b a=%h d=%h want 1 01 c022ffff", we, addr, wd); end
    step();
  endtask

  task automatic test_forced_fields();
    send(4'd2, 5'd7, 5'd5, 5'd0, 4'd0, 16'h0010, 1'b0);
    vectors++; if ({we, addr, wd} !== {1'b1, 8'd2, 32'hE005_0010}) begin
      miscompares++; $display("FAIL li got we=%b a=%h d=%h want 1 02 e0050010", we, addr, wd); end
    step();
    send(4'd7, 5'd3, 5'd4, 5'd0, 4'd0, 16'hFFFE, 1'b0);
    vectors++; if ({we, addr, wd} !== {1'b1, 8'd3, 32'hFC00_FFFE}) begin
      miscompares++; $display("FAIL b got we=%b a=%h d=%h want 1 03 fc00fffe", we, addr, wd); end
    step();
    send(4'd0, 5'd9, 5'd9, 5'd9, 4'd9, 16'h1234, 1'b0);
    vectors++; if ({we, addr, wd} !== {1'b1, 8'd4, 32'h0}) begin
      miscompares++; $display("FAIL nop got we=%b a=%h d=%h want 1 04 0", we, addr, wd); end
    step();
    send(4'd3, 5'd9, 5'd6, 5'd0, 4'd0, 16'hABCD, 1'b0);
    vectors++; if ({we, addr, wd} !== {1'b1, 8'd5, 32'hE406_ABCD}) begin
      miscompares++; $display("FAIL lui got we=%b a=%h d=%h want 1 05 e406abcd", we, addr, wd); end
    step();
  endtask

  task automatic test_bad_op();
    send(4'd15, 5'd1, 5'd1, 5'd1, 4'd1, 16'h1, 1'b0);
    vectors++; if ({bad, we, rdy, busy} !== 4'b1011) begin
      miscompares++; $display("FAIL bad_op got bad,we,rdy,busy=%b want 1011", {bad, we, rdy, busy}); end
    send(4'd11, 5'd2, 5'd3, 5'd0, 4'd0, 16'h0004, 1'b0);
    vectors++; if ({we, addr, wd} !== {1'b1, 8'd6, 32'h3C43_0004}) begin
      miscompares++; $display("FAIL bad_addr got we=%b a=%h d=%h want 1 06 3c430004", we, addr, wd); end
    step();
  endtask

  task automatic test_done_with_op();
    send(4'd13, 5'd1, 5'd2, 5'd0, 4'd0, 16'h0008, 1'b1);
    vectors++; if ({we, addr, wd} !== {1'b1, 8'd7, 32'h7C22_0008}) begin
      miscompares++; $display("FAIL sw_done got we=%b a=%h d=%h want 1 07 7c220008", we, addr, wd); end
    step();
    vectors++; if ({busy, we, rdy} !== 3'b100) begin
      miscompares++; $display("FAIL release_enter got busy,we,rdy=%b want 100", {busy, we, rdy}); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (cpu !== 1'b1) begin miscompares++; $display("FAIL hold%0d got cpu=%b want 1", k, cpu); end
      step();
    end
    vectors++; if ({cpu, busy} !== 2'b00) begin
      miscompares++; $display("FAIL released got cpu,busy=%b want 00", {cpu, busy}); end
    step(); step();
    vectors++; if (cpu !== 1'b0) begin miscompares++; $display("FAIL stay_released got cpu=%b want 0", cpu); end
  endtask

  task automatic test_overflow();
    logic [3:0]  k_tab [4] = '{4'd6, 4'd5, 4'd8, 4'd10};
    logic [4:0]  s_tab [4] = '{5'd1, 5'd3, 5'd0, 5'd31};
    logic [4:0]  d_tab [4] = '{5'd2, 5'd4, 5'd0, 5'd31};
    logic [15:0] i_tab [4] = '{16'h1234, 16'h00FF, 16'h0000, 16'h8000};
    logic [31:0] e_tab [4] = '{32'hCC22_1234, 32'hC864_00FF, 32'h0000_0000, 32'h0FFF_8000};
    ls_s = 1'b1;
    step();
    ls_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({we_s, addr_s} !== {1'b1, 2'(i)}) begin
        miscompares++; $display("FAIL sclear%0d got we=%b a=%h want 1 %h", i, we_s, addr_s, 2'(i)); end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      send_s(k_tab[i], s_tab[i], d_tab[i], 5'd0, 4'd0, i_tab[i]);
      vectors++; if ({we_s, addr_s, wd_s} !== {1'b1, 2'(i), e_tab[i]}) begin
        miscompares++; $display("FAIL sop%0d got we=%b a=%h d=%h want 1 %h %h", i, we_s, addr_s, wd_s, 2'(i), e_tab[i]); end
      step();
    end
    vectors++; if ({rdy_s, ovf_s} !== 2'b00) begin
      miscompares++; $display("FAIL full_ready got rdy,ovf=%b want 00", {rdy_s, ovf_s}); end
    ov_s = 1'b1;
    step();
    vectors++; if ({ovf_s, we_s, rdy_s} !== 3'b100) begin
      miscompares++; $display("FAIL overflow got ovf,we,rdy=%b want 100", {ovf_s, we_s, rdy_s}); end
    step();
    vectors++; if ({we_s, busy_s} !== 2'b01) begin
      miscompares++; $display("FAIL full_nowrite got we,busy=%b want 01", {we_s, busy_s}); end
    ov_s = 1'b0; ld_s = 1'b1;
    step();
    ld_s = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++; if ({cpu_s, busy_s} !== 2'b11) begin
        miscompares++; $display("FAIL shold%0d got cpu,busy=%b want 11", k, {cpu_s, busy_s}); end
      step();
    end
    vectors++; if ({cpu_s, busy_s, ovf_s} !== 3'b001) begin
      miscompares++; $display("FAIL srelease got cpu,busy,ovf=%b want 001", {cpu_s, busy_s, ovf_s}); end
    ls_s = 1'b1;
    step();
    ls_s = 1'b0;
    vectors++; if ({ovf_s, busy_s, cpu_s} !== 3'b011) begin
      miscompares++; $display("FAIL restart got ovf,busy,cpu=%b want 011", {ovf_s, busy_s, cpu_s}); end
  endtask

  task automatic test_reset_mid_write();
    ls = 1'b1;
    step();
    ls = 1'b0;
    repeat (256) step();
    vectors++; if ({bad, rdy} !== 2'b01) begin
      miscompares++; $display("FAIL restart_clr got bad,rdy=%b want 01", {bad, rdy}); end
    send(4'd15, 5'd0, 5'd0, 5'd0, 4'd0, 16'h0, 1'b0);
    send(4'd1, 5'd1, 5'd1, 5'd1, 4'd1, 16'h0, 1'b0);
    vectors++; if ({we, bad, addr} !== {1'b1, 1'b1, 8'd0}) begin
      miscompares++; $display("FAIL pre_reset got we=%b bad=%b a=%h want 1 1 00", we, bad, addr); end
    rst = 1'b1;
    #1;
    vectors++; if ({cpu, busy, we, rdy, bad, ovf} !== 6'b100000) begin
      miscompares++; $display("FAIL mid_reset got cpu,busy,we,rdy,bad,ovf=%b want 100000", {cpu, busy, we, rdy, bad, ovf}); end
    vectors++; if ({addr, wd} !== 40'h0) begin
      miscompares++; $display("FAIL mid_reset_bus got %h want 0", {addr, wd}); end
    step();
    rst = 1'b0;
    step();
    vectors++; if ({cpu, busy} !== 2'b10) begin
      miscompares++; $display("FAIL post_reset got cpu,busy=%b want 10", {cpu, busy}); end
  endtask

  initial begin
    rst = 1'b1;
    ls = 1'b0; ld = 1'b0; ov = 1'b0;
    ls_s = 1'b0; ld_s = 1'b0; ov_s = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 4'd0, 16'h0);
    test_reset();
    test_clear();
    test_alu_addi();
    test_forced_fields();
    test_bad_op();
    test_done_with_op();
    test_overflow();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
